// File: rtl/single_port_ram_no_change.sv
// Single-port block RAM, no-change write mode, registered output.
// Read data passes a read latch and an output register (2-cycle latency).
module single_port_ram_no_change #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 16,
    localparam int ADDR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_bus,
    input  logic [RAM_WIDTH-1:0]  data_input,
    input  logic                  write_enable,
    input  logic                  enable,
    input  logic                  register_enable,
    output logic [RAM_WIDTH-1:0]  data_output
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};
    logic [RAM_WIDTH-1:0] ram_data = '0;
    logic [RAM_WIDTH-1:0] out_q = '0;
    logic                 in_range;

    // Only matters when RAM_DEPTH is not a power of two.
    assign in_range = ({1'b0, address_bus} <= LAST_ADDR);

    always_ff @(posedge clock) begin
        if (enable) begin
            if (write_enable) begin
                if (in_range) begin
                    mem[address_bus] <= data_input;
                end
            end else begin
                ram_data <= in_range ? mem[address_bus] : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else if (register_enable) begin
            out_q <= ram_data;
        end
    end

    assign data_output = out_q;

endmodule

// File: tb/tb_single_port_ram_no_change.sv
// Scoreboard bench for single_port_ram_no_change.
// Driver queues the expected output per edge; a negedge monitor checks it.
module tb_single_port_ram_no_change;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] addr;
    logic [7:0] din;
    logic       we;
    logic       en;
    logic       re;
    logic [7:0] dout;

    logic [7:0] exp_q [$];
    string      name_q [$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    single_port_ram_no_change #(
        .RAM_WIDTH(8),
        .RAM_DEPTH(16)
    ) dut (
        .clock(clk),
        .reset(rst),
        .address_bus(addr),
        .data_input(din),
        .write_enable(we),
        .enable(en),
        .register_enable(re),
        .data_output(dout)
    );

    always #5 clk = ~clk;

    // Inputs for one edge; x is data_output expected right after that edge.
    task automatic tick(input logic e, input logic w, input logic [3:0] a,
                        input logic [7:0] d, input logic r, input logic s,
                        input logic [7:0] x, input string n);
        en = e;
        we = w;
        addr = a;
        din = d;
        re = r;
        rst = s;
        exp_q.push_back(x);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [7:0] x;
        string n;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (dout !== x) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, dout, x);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout queue=%0d", exp_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        tick(0, 0, 4'd0, 8'd0, 1, 1, 8'h00, "reset");
        tick(0, 0, 4'd0, 8'd0, 1, 1, 8'h00, "reset");

        for (int i = 0; i < 16; i++)
            tick(1, 1, 4'(i), 8'(i), 0, 0, 8'h00, "init_wr");
        for (int i = 0; i < 16; i++)
            tick(1, 0, 4'(i), 8'h00, 0, 0, 8'h00, "rd_regen_off");

        // ram_data holds 15, output 0
        for (int a = 0; a < 16; a++)
            for (int k = 0; k < 3; k++)
                tick(1, 0, 4'(a), 8'h00, 1, 0,
                     (k == 0) ? ((a == 0) ? 8'd15 : 8'(a - 1)) : 8'(a),
                     "rd_latency");

        tick(1, 0, 4'd9, 8'h00, 1, 1, 8'h00, "rst_pulse");
        tick(1, 0, 4'd9, 8'h00, 1, 1, 8'h00, "rst_pulse");
        tick(1, 0, 4'd9, 8'h00, 1, 0, 8'd9, "rd_after_rst");
        tick(1, 0, 4'd4, 8'h00, 1, 0, 8'd9, "rd_after_rst");
        tick(1, 0, 4'd4, 8'h00, 1, 0, 8'd4, "rd_after_rst");
        tick(1, 0, 4'd12, 8'h00, 1, 0, 8'd4, "rd_after_rst");
        tick(1, 0, 4'd12, 8'h00, 1, 0, 8'd12, "rd_after_rst");

        for (int i = 0; i < 16; i++)
            tick(1, 1, 4'(i), 8'(2 * i), 1, 0, 8'd12, "wr_nochange");
        tick(1, 0, 4'd7, 8'h00, 1, 0, 8'd12, "rd_2i");
        tick(1, 0, 4'd7, 8'h00, 1, 0, 8'd14, "rd_2i");

        for (int i = 0; i < 16; i++)
            tick(0, 1, 4'(i), 8'(4 * i), 1, 0, 8'd14, "dis_wr");
        for (int i = 0; i < 16; i++)
            tick(0, 0, 4'(i), 8'h00, 1, 0, 8'd14, "dis_rd");

        tick(1, 0, 4'd7, 8'h00, 1, 0, 8'd14, "reen_rd");
        tick(1, 0, 4'd7, 8'h00, 1, 0, 8'd14, "reen_rd");
        tick(1, 0, 4'd15, 8'h00, 1, 0, 8'd14, "reen_rd");
        tick(1, 0, 4'd15, 8'h00, 1, 0, 8'd30, "reen_rd");
        tick(1, 0, 4'd0, 8'h00, 1, 0, 8'd30, "reen_rd");
        tick(1, 0, 4'd0, 8'h00, 1, 0, 8'd0, "reen_rd");
        tick(1, 0, 4'd3, 8'h00, 1, 0, 8'd0, "reen_rd");
        tick(1, 0, 4'd3, 8'h00, 1, 0, 8'd6, "reen_rd");

        tick(1, 0, 4'd5, 8'h00, 1, 0, 8'd6, "rd5");
        tick(1, 0, 4'd5, 8'h00, 1, 0, 8'd10, "rd5");
        tick(1, 1, 4'd3, 8'hA5, 1, 0, 8'd10, "wr_a5_nochange");
        tick(1, 1, 4'd3, 8'hA5, 1, 0, 8'd10, "wr_a5_nochange");
        tick(1, 0, 4'd3, 8'h00, 1, 0, 8'd10, "rd_a5");
        tick(1, 0, 4'd3, 8'h00, 1, 0, 8'hA5, "rd_a5");
        tick(1, 0, 4'd3, 8'h00, 1, 0, 8'hA5, "rd_a5");

        // read of addr 5 during reset still loads the latch
        tick(1, 0, 4'd5, 8'h00, 1, 1, 8'h00, "rst_priority");
        tick(0, 0, 4'd0, 8'h00, 1, 0, 8'd10, "post_rst");
        tick(1, 0, 4'd3, 8'h00, 0, 0, 8'd10, "regen_hold");
        tick(0, 0, 4'd0, 8'h00, 0, 0, 8'd10, "regen_hold");
        tick(0, 0, 4'd0, 8'h00, 1, 0, 8'hA5, "regen_on");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
